snake_body_store: RTL and testbench

// - Owns the snake body coordinate table (segments behind the head) and updates it on each move step.
// - Streams every table entry cyclically as (body_count, snake_body_x, snake_body_y) to the renderer upstream of pixel generation.
// - Optionally scans the table for head/body self-collision after each move.

---
 rtl/snake_body_store.sv | 151 +++++++++++++++
 tb/tb_snake_body_store.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/snake_body_store.sv
// Snake body coordinate table: shifts in the old head on each move and streams every entry to the renderer.
// Compile with SNAKE_SELF_COLLISION_EN defined to add the post-move head/body collision scan.
module snake_body_store #(
  parameter int SNAKE_LENGTH_BIT = 4,
  parameter int SNAKE_LENGTH_MAX = 2**SNAKE_LENGTH_BIT,
  parameter int INIT_LENGTH      = 3,
  parameter int START_X          = 62,
  parameter int START_Y          = 40
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic                        move_tik,
  input  logic                        grow,
  input  logic [6:0]                  head_x,
  input  logic [6:0]                  head_y,
  input  logic [6:0]                  next_head_x,
  input  logic [6:0]                  next_head_y,
  output logic [SNAKE_LENGTH_BIT-1:0] body_count,
  output logic [6:0]                  snake_body_x,
  output logic [6:0]                  snake_body_y,
  output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
  output logic                        busy,
  output logic                        update_done,
  output logic                        self_hit
);

  localparam int LW = SNAKE_LENGTH_BIT;
  localparam logic [LW:0] LEN_MAX  = SNAKE_LENGTH_MAX[LW:0];
  localparam logic [LW:0] LEN_INIT = INIT_LENGTH[LW:0];

  typedef enum logic [1:0] {IDLE, UPDATE, SCAN} state_t;

  state_t        state;
  logic [6:0]    tab_x [SNAKE_LENGTH_MAX];
  logic [6:0]    tab_y [SNAKE_LENGTH_MAX];
  // One extra bit so a full table (MAX entries) is distinct from empty;
  // the port shows it modulo MAX, so tail index snake_length-1 still wraps to MAX-1.
  logic [LW:0]   len;
  logic          grow_q;
  logic [6:0]    cap_hx, cap_hy;
  logic [LW-1:0] next_count;

`ifdef SNAKE_SELF_COLLISION_EN
  logic [6:0]    cap_nx, cap_ny;
  logic [LW-1:0] scan_j;
`else
  logic          done_pend;
  logic          unused_next;
  assign unused_next = ^{next_head_x, next_head_y};
  assign self_hit    = 1'b0;
`endif

  assign snake_length = len[LW-1:0];
  assign next_count   = body_count + 1'b1;

  // Free-running stream: index and data are registered together so they always pair.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      body_count   <= '0;
      snake_body_x <= 7'(START_X - 1);
      snake_body_y <= 7'(START_Y);
    end else begin
      // NOTE: all sequential state uses non-blocking assignment so every register
      // samples pre-edge values, regardless of statement or block order.
      body_count   <= next_count;
      snake_body_x <= tab_x[next_count];
      snake_body_y <= tab_y[next_count];
    end
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      // NOTE: the table is reset entry by entry because its reset contents are the
      // starting snake; that is why it lives in flops rather than a RAM macro.
      for (int i = 0; i < SNAKE_LENGTH_MAX; i++) begin
        tab_x[i] <= (i < INIT_LENGTH) ? 7'(START_X - 1 - i) : 7'd0;
        tab_y[i] <= (i < INIT_LENGTH) ? 7'(START_Y) : 7'd0;
      end
      state       <= IDLE;
      len         <= LEN_INIT;
      grow_q      <= 1'b0;
      cap_hx      <= '0;
      cap_hy      <= '0;
      busy        <= 1'b0;
      update_done <= 1'b0;
`ifdef SNAKE_SELF_COLLISION_EN
      cap_nx      <= '0;
      cap_ny      <= '0;
      scan_j      <= '0;
      self_hit    <= 1'b0;
`else
      done_pend   <= 1'b0;
`endif
    end else begin
`ifdef SNAKE_SELF_COLLISION_EN
      update_done <= 1'b0;
`else
      update_done <= done_pend;
      done_pend   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (move_tik) begin
            grow_q   <= grow;
            cap_hx   <= head_x;
            cap_hy   <= head_y;
            busy     <= 1'b1;
            state    <= UPDATE;
`ifdef SNAKE_SELF_COLLISION_EN
            cap_nx   <= next_head_x;
            cap_ny   <= next_head_y;
            self_hit <= 1'b0;
`endif
          end
        end
        UPDATE: begin
          for (int i = SNAKE_LENGTH_MAX - 1; i > 0; i--) begin
            tab_x[i] <= tab_x[i-1];
            tab_y[i] <= tab_y[i-1];
          end
          tab_x[0] <= cap_hx;
          tab_y[0] <= cap_hy;
          if (grow_q && (len < LEN_MAX)) len <= len + 1'b1;
`ifdef SNAKE_SELF_COLLISION_EN
          scan_j <= '0;
          state  <= SCAN;
`else
          busy      <= 1'b0;
          done_pend <= 1'b1;
          state     <= IDLE;
`endif
        end
`ifdef SNAKE_SELF_COLLISION_EN
        SCAN: begin
          // Scan sees the table after the shift, so the old head counts as body.
          if ((tab_x[scan_j] == cap_nx) && (tab_y[scan_j] == cap_ny)) self_hit <= 1'b1;
          if ({1'b0, scan_j} == len - 1'b1) begin
            busy        <= 1'b0;
            update_done <= 1'b1;
            state       <= IDLE;
          end else begin
            scan_j <= scan_j + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_store.sv
// Self-checking bench for snake_body_store: directed moves plus random moves against a queue model of the body.
module tb_snake_body_store;

  logic       clock_25 = 1'b0;
  logic       reset    = 1'b0;
  logic       move_tik = 1'b0;
  logic       grow     = 1'b0;
  logic [6:0] head_x = '0, head_y = '0, next_head_x = '0, next_head_y = '0;
  logic [3:0] body_count, snake_length;
  logic [6:0] snake_body_x, snake_body_y;
  logic       busy, update_done, self_hit;

  snake_body_store dut (
    .clock_25(clock_25), .reset(reset), .move_tik(move_tik), .grow(grow),
    .head_x(head_x), .head_y(head_y), .next_head_x(next_head_x), .next_head_y(next_head_y),
    .body_count(body_count), .snake_body_x(snake_body_x), .snake_body_y(snake_body_y),
    .snake_length(snake_length), .busy(busy), .update_done(update_done), .self_hit(self_hit)
  );

  always #20 clock_25 = ~clock_25;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [6:0] m_x[$];
  logic [6:0] m_y[$];
  int m_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_25);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    m_x = {};
    m_y = {};
    for (int i = 0; i < 16; i++) begin
      m_x.push_back((i < 3) ? 7'(61 - i) : 7'd0);
      m_y.push_back((i < 3) ? 7'd40 : 7'd0);
    end
    m_len = 3;
  endtask

  task automatic check_stream();
    int idx;
    for (int n = 0; n < 16; n++) begin
      step();
      idx = cyc % 16;
      check("stream", {body_count, snake_body_x, snake_body_y}, {idx[3:0], m_x[idx], m_y[idx]});
    end
  endtask

  task automatic do_move(input logic g, input logic [6:0] hx, input logic [6:0] hy,
                         input logic [6:0] nx, input logic [6:0] ny, input bit dbl);
    int  waited;
    int  exp_lat;
    bit  exp_hit;
    move_tik = 1'b1; grow = g;
    head_x = hx; head_y = hy; next_head_x = nx; next_head_y = ny;
    step();
    if (!dbl) move_tik = 1'b0;
    check("busy_after_tik", busy, 1);
    step();
    move_tik = 1'b0; grow = 1'b0;
    m_x.push_front(hx); m_y.push_front(hy);
    void'(m_x.pop_back()); void'(m_y.pop_back());
    if (g && m_len < 16) m_len++;
    exp_hit = 1'b0;
`ifdef SNAKE_SELF_COLLISION_EN
    for (int i = 0; i < m_len; i++)
      if (m_x[i] == nx && m_y[i] == ny) exp_hit = 1'b1;
    exp_lat = 1 + m_len;
`else
    exp_lat = 2;
`endif
    waited = 1;
    while (update_done !== 1'b1 && waited < 60) begin
      step();
      waited++;
    end
    check("done_latency", waited, exp_lat);
    check("busy_at_done", busy, 0);
    check("self_hit", self_hit, exp_hit);
    check("length", snake_length, m_len % 16);
    step();
    check("done_one_cycle", update_done, 0);
  endtask

  initial begin
    bit seen_done;
    logic [6:0] rx, ry;
    model_reset();
    step(); step();
    check("rst_length", snake_length, 3);
    check("rst_count", body_count, 0);
    check("rst_xy", {snake_body_x, snake_body_y}, {7'd61, 7'd40});
    check("rst_flags", {busy, update_done, self_hit}, 3'b000);
    reset = 1'b1; cyc = 0;
    check_stream();

    do_move(1'b0, 7'd62, 7'd40, 7'd63, 7'd40, 1'b0);
    check_stream();
    do_move(1'b1, 7'd63, 7'd40, 7'd64, 7'd40, 1'b0);
    check_stream();

    // grow without move_tik has no effect
    grow = 1'b1;
    repeat (5) step();
    grow = 1'b0;
    check("grow_no_tik", snake_length, 4);

    // build body (10,10),(10,11),(11,11),(11,10) then aim next head at (11,11)
    do_move(1'b0, 7'd11, 7'd10, 7'd11, 7'd11, 1'b0);
    do_move(1'b0, 7'd11, 7'd11, 7'd10, 7'd11, 1'b0);
    do_move(1'b0, 7'd10, 7'd11, 7'd10, 7'd10, 1'b0);
    do_move(1'b0, 7'd10, 7'd10, 7'd11, 7'd11, 1'b0);
    check_stream();
    do_move(1'b0, 7'd11, 7'd11, 7'd100, 7'd100, 1'b0);

    // back-to-back move_tik: second one dropped
    do_move(1'b0, 7'd12, 7'd11, 7'd13, 7'd11, 1'b1);
    check_stream();

    // fill to max length, then one more grow saturates
    for (int i = 0; i < 20 && m_len < 16; i++)
      do_move(1'b1, 7'(20 + i), 7'd50, 7'(21 + i), 7'd50, 1'b0);
    check("full_length", snake_length, 0);
    do_move(1'b1, 7'd90, 7'd90, 7'd91, 7'd90, 1'b0);
    check_stream();

    // random moves in a small field so collisions happen
    for (int i = 0; i < 24; i++) begin
      rx = 7'($urandom_range(0, 3));
      ry = 7'($urandom_range(0, 3));
      do_move(1'($urandom_range(0, 1)), rx, ry, 7'($urandom_range(0, 3)), 7'($urandom_range(0, 3)), 1'b0);
    end
    check_stream();

    // reset in the middle of a move
    move_tik = 1'b1; head_x = 7'd5; head_y = 7'd5; next_head_x = 7'd6; next_head_y = 7'd5;
    step();
    move_tik = 1'b0;
    step();
    #5 reset = 1'b0;
    #1;
    model_reset();
    check("midrst_length", snake_length, 3);
    check("midrst_count", body_count, 0);
    check("midrst_xy", {snake_body_x, snake_body_y}, {7'd61, 7'd40});
    check("midrst_flags", {busy, update_done, self_hit}, 3'b000);
    step();
    reset = 1'b1; cyc = 0;
    seen_done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (update_done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    check("midrst_no_done", seen_done, 0);
    check_stream();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
